fre_word_tx_module: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/fre_word_tx_module.sv | 125 ++++++++++++
 tb/tb_fre_word_tx_module.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared frame definitions for the frequency-word UART link (transmit and receive sides).
// Holds the header byte, payload size, transmit state encoding and the frame checksum.
package uart_frame_pkg;

   localparam logic [7:0] FRAME_HEADER  = 8'h01;
   localparam int         PAYLOAD_BYTES = 4;

   typedef enum logic [2:0] {
      IDLE,
      STROBE,
      WAIT,
      GAP,
      DONE
   } tx_state_t;

   // XOR of the four payload bytes; the header is not covered.
   function automatic logic [7:0] frame_xor8(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/fre_word_tx_module.sv
// Serialises a 32-bit frequency word as HEADER + 4 bytes MSB-first over a strobe/done byte link.
// Define FRE_TX_CHECKSUM_EN to append a sixth XOR checksum byte.
module fre_word_tx_module
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] HEADER     = FRAME_HEADER,
   parameter int         GAP_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        send_req,
   input  logic [31:0] fre_word,
   input  logic        tx_done_sig,
   output logic [7:0]  tx_data,
   output logic        tx_en_sig,
   output logic        busy,
   output logic        frame_done
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   // GAP is entered after the done cycle and left when the counter reads zero,
   // so loading GAP_CYCLES-1 yields exactly GAP_CYCLES idle cycles.
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

`ifdef FRE_TX_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES + 1);
`else
   localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES);
`endif

   tx_state_t        state_reg, state_next;
   logic [2:0]       idx_reg, idx_next;
   logic [GAP_W-1:0] gap_reg, gap_next;
   logic [31:0]      word_reg, word_next;
   logic [7:0]       tx_data_reg, tx_data_next;

   logic [2:0]       idx_inc;
   logic [7:0]       byte_sel;

   assign idx_inc = idx_reg + 3'd1;

   // Byte for the upcoming index; only consulted when advancing past the header.
   always_comb begin
      byte_sel = HEADER;
      case (idx_inc)
         3'd1:    byte_sel = word_reg[31:24];
         3'd2:    byte_sel = word_reg[23:16];
         3'd3:    byte_sel = word_reg[15:8];
         3'd4:    byte_sel = word_reg[7:0];
`ifdef FRE_TX_CHECKSUM_EN
         3'd5:    byte_sel = frame_xor8(word_reg);
`endif
         default: byte_sel = HEADER;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      gap_next     = gap_reg;
      word_next    = word_reg;
      tx_data_next = tx_data_reg;
      case (state_reg)
         IDLE: begin
            if (send_req) begin
               word_next    = fre_word;
               idx_next     = 3'd0;
               tx_data_next = HEADER;
               state_next   = STROBE;
            end
         end
         STROBE: state_next = WAIT;
         WAIT: begin
            if (tx_done_sig) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = DONE;
               end else if (GAP_CYCLES == 0) begin
                  idx_next     = idx_inc;
                  tx_data_next = byte_sel;
                  state_next   = STROBE;
               end else begin
                  gap_next   = GAP_LOAD;
                  state_next = GAP;
               end
            end
         end
         GAP: begin
            if (gap_reg == '0) begin
               idx_next     = idx_inc;
               tx_data_next = byte_sel;
               state_next   = STROBE;
            end else begin
               gap_next = gap_reg - GAP_W'(1);
            end
         end
         DONE: begin
            idx_next   = 3'd0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         idx_reg     <= 3'd0;
         gap_reg     <= '0;
         word_reg    <= 32'h0;
         tx_data_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         gap_reg     <= gap_next;
         word_reg    <= word_next;
         tx_data_reg <= tx_data_next;
      end
   end

   assign tx_data    = tx_data_reg;
   assign tx_en_sig  = (state_reg == STROBE);
   assign busy       = (state_reg == STROBE) || (state_reg == WAIT) || (state_reg == GAP);
   assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_fre_word_tx_module.sv
// Bench for fre_word_tx_module: two instances (GAP_CYCLES 0 and 16) share stimulus and are
// checked every cycle against a timestamp model; FRE_TX_CHECKSUM_EN selects the 6-byte frame.
module tb_fre_word_tx_module;
   import uart_frame_pkg::*;

   localparam int NDUT = 2;
   localparam int LOGN = 128;
`ifdef FRE_TX_CHECKSUM_EN
   localparam int NBYTES = 6;
`else
   localparam int NBYTES = 5;
`endif

   logic        clk = 1'b0;
   logic        rst, send_req, force_done;
   logic [31:0] fre_word;
   logic [NDUT-1:0] tx_done_sig, tx_en_sig, busy, frame_done;
   logic [7:0]  tx_data [NDUT];

   always #5 clk = ~clk;

   // Each instance gets its own byte-transmitter stand-in returning done 3 cycles after a strobe.
   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      logic rdone = 1'b0;
      int   cnt   = 0;

      assign tx_done_sig[gi] = rdone | force_done;

      fre_word_tx_module #(
         .HEADER     (8'h01),
         .GAP_CYCLES ((gi == 0) ? 0 : 16)
      ) dut (
         .clk         (clk),
         .rst         (rst),
         .send_req    (send_req),
         .fre_word    (fre_word),
         .tx_done_sig (tx_done_sig[gi]),
         .tx_data     (tx_data[gi]),
         .tx_en_sig   (tx_en_sig[gi]),
         .busy        (busy[gi]),
         .frame_done  (frame_done[gi])
      );

      always @(posedge clk) begin
         #2;
         rdone = 1'b0;
         if (tx_en_sig[gi] === 1'b1) begin
            cnt = 3;
         end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) rdone = 1'b1;
         end
      end
   end

   // Model: expected strobe / frame_done cycles plus the frame's byte list.
   int         cyc;
   int         compared, mismatched;
   int         m_strobe_at [NDUT];
   int         m_fd_at     [NDUT];
   int         m_idx       [NDUT];
   bit         m_inframe   [NDUT];
   bit         m_waiting   [NDUT];
   logic [7:0] m_data      [NDUT];
   logic [7:0] m_bytes     [NDUT][6];
   int         last_done_c [NDUT];
   int         n_fd        [NDUT];
   int         n_log       [NDUT];
   logic [7:0] log_b       [NDUT][LOGN];
   int         log_g       [NDUT][LOGN];
   logic [7:0] exp_f       [6];
   int         exp_gap     [NDUT];

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 16;
   endfunction

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
      end
   endtask

   task automatic model_step(input int d);
      bit exp_en, exp_fd, exp_busy;
      logic [7:0] b1, b2, b3, b4;
      exp_en   = (cyc == m_strobe_at[d]);
      exp_fd   = (cyc == m_fd_at[d]);
      exp_busy = m_inframe[d];
      if (exp_en) m_data[d] = m_bytes[d][m_idx[d]];
      chk("tx_en_sig", d, 32'(tx_en_sig[d]), 32'(exp_en));
      chk("busy", d, 32'(busy[d]), 32'(exp_busy));
      chk("frame_done", d, 32'(frame_done[d]), 32'(exp_fd));
      chk("tx_data", d, 32'(tx_data[d]), 32'(m_data[d]));
      if (tx_en_sig[d] === 1'b1) begin
         if (n_log[d] < LOGN) begin
            log_b[d][n_log[d]] = tx_data[d];
            log_g[d][n_log[d]] = cyc - last_done_c[d];
            n_log[d]++;
         end
         $display("dut%0d cycle %0d: strobe byte %02h (%0d cycles after last done)",
                  d, cyc, tx_data[d], cyc - last_done_c[d]);
      end
      if (frame_done[d] === 1'b1) n_fd[d]++;

      if (rst) begin
         m_inframe[d]   = 1'b0;
         m_waiting[d]   = 1'b0;
         m_strobe_at[d] = -1;
         m_fd_at[d]     = -1;
         m_idx[d]       = 0;
         m_data[d]      = 8'h00;
      end else begin
         if (m_waiting[d] && tx_done_sig[d]) begin
            m_waiting[d]   = 1'b0;
            last_done_c[d] = cyc;
            if (m_idx[d] == NBYTES - 1) begin
               m_inframe[d] = 1'b0;
               m_fd_at[d]   = cyc + 1;
            end else begin
               m_idx[d]++;
               m_strobe_at[d] = cyc + 1 + gap_of(d);
            end
         end
         if (exp_en) m_waiting[d] = 1'b1;
         if (!exp_busy && !exp_fd && send_req) begin
            b1 = fre_word[31:24];
            b2 = fre_word[23:16];
            b3 = fre_word[15:8];
            b4 = fre_word[7:0];
            m_bytes[d][0] = 8'h01;
            m_bytes[d][1] = b1;
            m_bytes[d][2] = b2;
            m_bytes[d][3] = b3;
            m_bytes[d][4] = b4;
            m_bytes[d][5] = b1 ^ b2 ^ b3 ^ b4;
            m_idx[d]       = 0;
            m_inframe[d]   = 1'b1;
            m_strobe_at[d] = cyc + 1;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) model_step(d);
      cyc++;
      @(posedge clk);
      #2;
   endtask

   function automatic bit model_busy();
      bit b = 1'b0;
      for (int d = 0; d < NDUT; d++)
         if (m_inframe[d] || m_fd_at[d] >= cyc) b = 1'b1;
      return b;
   endfunction

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (model_busy() && n < budget) begin
         tick();
         n++;
      end
      if (model_busy()) begin
         compared++;
         mismatched++;
         $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
      end
      tick();
   endtask

   task automatic set_exp(input logic [31:0] w, input logic [7:0] cks);
      exp_f[0] = 8'h01;
      exp_f[1] = w[31:24];
      exp_f[2] = w[23:16];
      exp_f[3] = w[15:8];
      exp_f[4] = w[7:0];
      exp_f[5] = cks;
   endtask

   task automatic chk_frame(input string name, input int d, input int base);
      for (int k = 0; k < NBYTES; k++)
         chk(name, d, 32'(log_b[d][base + k]), 32'(exp_f[k]));
   endtask

   int base [NDUT];
   int fd0  [NDUT];
   int n;

   initial begin
      rst = 1'b1; send_req = 1'b0; force_done = 1'b0; fre_word = 32'h0;
      cyc = 0; compared = 0; mismatched = 0;
      exp_gap[0] = 1;
      exp_gap[1] = 17;
      for (int d = 0; d < NDUT; d++) begin
         m_strobe_at[d] = -1; m_fd_at[d] = -1; m_idx[d] = 0;
         m_inframe[d] = 1'b0; m_waiting[d] = 1'b0; m_data[d] = 8'h00;
         last_done_c[d] = -1000; n_fd[d] = 0; n_log[d] = 0;
      end

      repeat (3) tick();
      rst = 1'b0;
      tick();
      for (int d = 0; d < NDUT; d++) begin
         chk("reset_tx_data", d, 32'(tx_data[d]), 32'h00);
         chk("reset_busy", d, 32'(busy[d]), 32'h0);
         chk("reset_tx_en", d, 32'(tx_en_sig[d]), 32'h0);
      end
      chk("xor_pin", 0, 32'(frame_xor8(32'h01B4E81B)), 32'h46);

      // Frame 1, with fre_word changed after capture and a stray send_req mid-frame.
      for (int d = 0; d < NDUT; d++) begin base[d] = n_log[d]; fd0[d] = n_fd[d]; end
      fre_word = 32'h01B4E81B; send_req = 1'b1;
      tick();
      send_req = 1'b0; fre_word = 32'hDEADBEEF;
      repeat (8) tick();
      fre_word = 32'hFFFFFFFF; send_req = 1'b1;
      tick();
      send_req = 1'b0;
      wait_idle(400, "frame1_idle");
      set_exp(32'h01B4E81B, 8'h46);
      for (int d = 0; d < NDUT; d++) begin
         chk_frame("frame1_byte", d, base[d]);
         chk("frame1_nbytes", d, 32'(n_log[d] - base[d]), 32'(NBYTES));
         chk("frame1_done_count", d, 32'(n_fd[d] - fd0[d]), 32'd1);
         chk("byte_gap", d, 32'(log_g[d][base[d] + NBYTES - 1]), 32'(exp_gap[d]));
      end

      // Reset during WAIT of byte 2; the pending done lands in IDLE.
      for (int d = 0; d < NDUT; d++) begin base[d] = n_log[d]; fd0[d] = n_fd[d]; end
      fre_word = 32'hCAFEF00D; send_req = 1'b1;
      tick();
      send_req = 1'b0;
      n = 0;
      while (n_log[0] - base[0] < 3 && n < 100) begin tick(); n++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      for (int d = 0; d < NDUT; d++) begin
         chk("rst_tx_data", d, 32'(tx_data[d]), 32'h00);
         chk("rst_busy", d, 32'(busy[d]), 32'h0);
         chk("rst_no_frame_done", d, 32'(n_fd[d] - fd0[d]), 32'd0);
      end
      chk("rst_strobes", 0, 32'(n_log[0] - base[0]), 32'd3);

      // Full frame after the abort starts again from the header.
      for (int d = 0; d < NDUT; d++) begin base[d] = n_log[d]; fd0[d] = n_fd[d]; end
      fre_word = 32'h12345678; send_req = 1'b1;
      tick();
      send_req = 1'b0;
      wait_idle(400, "frame2_idle");
      set_exp(32'h12345678, 8'h08);
      for (int d = 0; d < NDUT; d++) begin
         chk_frame("frame2_byte", d, base[d]);
         chk("frame2_done_count", d, 32'(n_fd[d] - fd0[d]), 32'd1);
      end

      // Done pulse while idle must not start or end anything.
      for (int d = 0; d < NDUT; d++) begin base[d] = n_log[d]; fd0[d] = n_fd[d]; end
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      repeat (3) tick();
      for (int d = 0; d < NDUT; d++) begin
         chk("idle_done_strobes", d, 32'(n_log[d] - base[d]), 32'd0);
         chk("idle_done_frame_done", d, 32'(n_fd[d] - fd0[d]), 32'd0);
      end

      // send_req held high: back-to-back frames.
      for (int d = 0; d < NDUT; d++) begin base[d] = n_log[d]; fd0[d] = n_fd[d]; end
      fre_word = 32'hA5A50F0F; send_req = 1'b1;
      n = 0;
      while (n_fd[0] - fd0[0] < 2 && n < 300) begin tick(); n++; end
      send_req = 1'b0;
      wait_idle(600, "b2b_idle");
      set_exp(32'hA5A50F0F, 8'h00);
      chk_frame("b2b_frame_a", 0, base[0]);
      chk_frame("b2b_frame_b", 0, base[0] + NBYTES);
      chk("b2b_restart_gap", 0, 32'(log_g[0][base[0] + NBYTES]), 32'd3);
      chk("b2b_min_frames", 0, 32'(n_fd[0] - fd0[0] >= 2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
